// File: rtl/obstacle_spawner.sv
// Multi-slot random obstacle placer: an always-running 16-bit LFSR feeds a small
// rejection-sampling FSM that fills N_OBJ (x, y) slots read through a registered port.
module obstacle_spawner #(
    parameter int          N_OBJ   = 4,
    parameter int          IDX_W   = 2,
    parameter int          COORD_W = 11,
    parameter int          X_MIN   = 0,
    parameter int          X_MAX   = 639,
    parameter int          Y_MIN   = 0,
    parameter int          Y_MAX   = 479,
    parameter logic [15:0] SEED    = 16'h0004,
    parameter int          MAX_TRY = 15
) (
    input  logic               pixel_clk,
    input  logic               reset,
    input  logic               spawn_req,
    input  logic [IDX_W-1:0]   spawn_idx,
    input  logic               clear_req,
    output logic               spawn_busy,
    output logic               spawn_done,
    output logic [N_OBJ-1:0]   valid_mask,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    output logic               rd_valid
);

    typedef enum logic [1:0] {IDLE, GEN_X, GEN_Y, COMMIT} state_t;

    localparam int TRY_W = (MAX_TRY < 2) ? 1 : $clog2(MAX_TRY + 1);
    localparam logic [15:0]        SEED_C    = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [COORD_W-1:0] XMIN_C    = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0] XMAX_C    = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] YMIN_C    = COORD_W'(Y_MIN);
    localparam logic [COORD_W-1:0] YMAX_C    = COORD_W'(Y_MAX);
    localparam logic [TRY_W-1:0]   MAX_TRY_C = TRY_W'(MAX_TRY);

    function automatic logic in_window(input logic [COORD_W-1:0] v,
                                       input logic [COORD_W-1:0] lo,
                                       input logic [COORD_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [TRY_W-1:0]   try_q, try_d;
    logic               pend_q, pend_d;
    logic [IDX_W-1:0]   slot_q, slot_d;
    logic [COORD_W-1:0] x_tmp_q, x_tmp_d, y_tmp_q, y_tmp_d;
    logic               done_q, done_d;
    logic [N_OBJ-1:0]   valid_q, valid_d;
    logic [COORD_W-1:0] slot_x_q [N_OBJ];
    logic [COORD_W-1:0] slot_y_q [N_OBJ];
    logic [COORD_W-1:0] rd_x_q, rd_x_d, rd_y_q, rd_y_d;
    logic               rd_valid_q, rd_valid_d;
    logic [COORD_W-1:0] r;
    logic               idx_ok, try_last, accept;

    assign r      = lfsr_q[COORD_W-1:0];
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_comb begin
        state_d  = state_q;
        try_d    = try_q;
        x_tmp_d  = x_tmp_q;
        y_tmp_d  = y_tmp_q;
        idx_ok   = 1'b0;
        try_last = ((try_q + TRY_W'(1)) == MAX_TRY_C);
        for (int i = 0; i < N_OBJ; i++) begin
            if (spawn_idx == IDX_W'(i)) idx_ok = 1'b1;
        end
        unique case (state_q)
            IDLE: if (pend_q) state_d = GEN_X;
            GEN_X: begin
                if (in_window(r, XMIN_C, XMAX_C)) begin
                    x_tmp_d = r;
                    try_d   = '0;
                    state_d = GEN_Y;
                end else if (try_last) begin
                    x_tmp_d = XMIN_C;
                    try_d   = '0;
                    state_d = GEN_Y;
                end else begin
                    try_d = try_q + TRY_W'(1);
                end
            end
            GEN_Y: begin
                if (in_window(r, YMIN_C, YMAX_C)) begin
                    y_tmp_d = r;
                    try_d   = '0;
                    state_d = COMMIT;
                end else if (try_last) begin
                    y_tmp_d = YMIN_C;
                    try_d   = '0;
                    state_d = COMMIT;
                end else begin
                    try_d = try_q + TRY_W'(1);
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A request is taken only when the FSM will be idle next cycle, so the
        // COMMIT edge can accept a back-to-back spawn while GEN_* ignore it.
        accept = spawn_req && idx_ok && (state_d == IDLE);
        pend_d = accept;
        slot_d = accept ? spawn_idx : slot_q;
        done_d = (state_q == COMMIT);
    end

    always_comb begin
        valid_d = clear_req ? '0 : valid_q;
        for (int i = 0; i < N_OBJ; i++) begin
            if (state_q == COMMIT && slot_q == IDX_W'(i)) valid_d[i] = 1'b1;
        end
        rd_x_d     = '0;
        rd_y_d     = '0;
        rd_valid_d = 1'b0;
        for (int i = 0; i < N_OBJ; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_x_d     = slot_x_q[i];
                rd_y_d     = slot_y_q[i];
                rd_valid_d = valid_q[i];
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED_C;
            try_q      <= '0;
            pend_q     <= 1'b0;
            slot_q     <= '0;
            x_tmp_q    <= '0;
            y_tmp_q    <= '0;
            done_q     <= 1'b0;
            valid_q    <= '0;
            rd_x_q     <= '0;
            rd_y_q     <= '0;
            rd_valid_q <= 1'b0;
            for (int i = 0; i < N_OBJ; i++) begin
                slot_x_q[i] <= '0;
                slot_y_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            try_q      <= try_d;
            pend_q     <= pend_d;
            slot_q     <= slot_d;
            x_tmp_q    <= x_tmp_d;
            y_tmp_q    <= y_tmp_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            rd_x_q     <= rd_x_d;
            rd_y_q     <= rd_y_d;
            rd_valid_q <= rd_valid_d;
            for (int i = 0; i < N_OBJ; i++) begin
                if (state_q == COMMIT && slot_q == IDX_W'(i)) begin
                    slot_x_q[i] <= x_tmp_q;
                    slot_y_q[i] <= y_tmp_q;
                end
            end
        end
    end

    assign spawn_busy = (state_q != IDLE);
    assign spawn_done = done_q;
    assign valid_mask = valid_q;
    assign rd_x       = rd_x_q;
    assign rd_y       = rd_y_q;
    assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Bench for obstacle_spawner: three configurations (full window, narrow window,
// default window) checked against a rejection-sampling model of the spawn rules.
module tb_obstacle_spawner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req  [3];
    logic [2:0]  idx  [3];
    logic        clr  [3];
    logic [2:0]  rdi  [3];
    logic        busy [3];
    logic        done [3];
    logic [3:0]  mask [3];
    logic [10:0] rdx  [3];
    logic [10:0] rdy  [3];
    logic        rdv  [3];

    // d0: full window, 3-bit index; d1: single-point window; d2: default window
    int xlo [3] = '{0, 100, 0};
    int xhi [3] = '{2047, 100, 639};
    int ylo [3] = '{0, 200, 0};
    int yhi [3] = '{2047, 200, 479};
    int mt  [3] = '{15, 3, 15};

    obstacle_spawner #(.N_OBJ(4), .IDX_W(3), .COORD_W(11), .X_MIN(0), .X_MAX(2047),
                       .Y_MIN(0), .Y_MAX(2047), .SEED(16'h0004), .MAX_TRY(15)) u_full (
        .pixel_clk(clk), .reset(reset), .spawn_req(req[0]), .spawn_idx(idx[0]),
        .clear_req(clr[0]), .spawn_busy(busy[0]), .spawn_done(done[0]),
        .valid_mask(mask[0]), .rd_idx(rdi[0]), .rd_x(rdx[0]), .rd_y(rdy[0]),
        .rd_valid(rdv[0]));

    obstacle_spawner #(.N_OBJ(4), .IDX_W(2), .COORD_W(11), .X_MIN(100), .X_MAX(100),
                       .Y_MIN(200), .Y_MAX(200), .SEED(16'h0004), .MAX_TRY(3)) u_narrow (
        .pixel_clk(clk), .reset(reset), .spawn_req(req[1]), .spawn_idx(idx[1][1:0]),
        .clear_req(clr[1]), .spawn_busy(busy[1]), .spawn_done(done[1]),
        .valid_mask(mask[1]), .rd_idx(rdi[1][1:0]), .rd_x(rdx[1]), .rd_y(rdy[1]),
        .rd_valid(rdv[1]));

    obstacle_spawner u_dflt (
        .pixel_clk(clk), .reset(reset), .spawn_req(req[2]), .spawn_idx(idx[2][1:0]),
        .clear_req(clr[2]), .spawn_busy(busy[2]), .spawn_done(done[2]),
        .valid_mask(mask[2]), .rd_idx(rdi[2][1:0]), .rd_x(rdx[2]), .rd_y(rdy[2]),
        .rd_valid(rdv[2]));

    int n_assert = 0;
    int n_fail   = 0;

    int mmask [3];
    int mx [3][4];
    int my [3][4];

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        int   taps [4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        foreach (taps[i]) fb ^= v[taps[i]-1];
        return {v[14:0], fb};
    endfunction

    logic [15:0] m_lfsr;
    always @(posedge clk) m_lfsr <= reset ? 16'h0004 : lfsr_next(m_lfsr);

    // Draw x then y by rejection sampling, one LFSR value per cycle; lat counts
    // edges from the accepting edge to the edge after which spawn_done is seen.
    function automatic void spawn_model(input logic [15:0] l0, input int d,
                                        output int ex, output int ey, output int lat);
        logic [15:0] v = l0;
        int r;
        int tries;
        int cyc = 0;
        tries = 0;
        while (1) begin
            r = int'(v[10:0]); v = lfsr_next(v); cyc++;
            if (r >= xlo[d] && r <= xhi[d]) begin ex = r; break; end
            tries++;
            if (tries == mt[d]) begin ex = xlo[d]; break; end
        end
        tries = 0;
        while (1) begin
            r = int'(v[10:0]); v = lfsr_next(v); cyc++;
            if (r >= ylo[d] && r <= yhi[d]) begin ey = r; break; end
            tries++;
            if (tries == mt[d]) begin ey = ylo[d]; break; end
        end
        lat = cyc + 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check_slot(input int d, input int slot);
        rdi[d] = 3'(slot);
        tick();
        chk("rd_x",     32'(rdx[d]), (slot < 4) ? 32'(mx[d][slot]) : 32'd0);
        chk("rd_y",     32'(rdy[d]), (slot < 4) ? 32'(my[d][slot]) : 32'd0);
        chk("rd_valid", 32'(rdv[d]), (slot < 4) ? 32'((mmask[d] >> slot) & 1) : 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b0; idx[d] = '0; clr[d] = 1'b0; rdi[d] = '0;
            mmask[d] = 0;
            for (int s = 0; s < 4; s++) begin mx[d][s] = 0; my[d][s] = 0; end
        end
        repeat (3) tick();
        for (int d = 0; d < 3; d++) begin
            chk("reset_busy",  32'(busy[d]), 0);
            chk("reset_done",  32'(done[d]), 0);
            chk("reset_mask",  32'(mask[d]), 0);
            chk("reset_rdx",   32'(rdx[d]),  0);
            chk("reset_rdy",   32'(rdy[d]),  0);
            chk("reset_rdv",   32'(rdv[d]),  0);
        end
        reset = 1'b0;
    endtask

    task automatic spawn(input int d, input int slot, input bit clr_commit, input int intrude);
        logic [15:0] l0;
        int ex, ey, lat, n;
        req[d] = 1'b1; idx[d] = 3'(slot);
        tick();
        req[d] = 1'b0;
        tick();
        l0 = m_lfsr;
        spawn_model(l0, d, ex, ey, lat);
        n = 1;
        while (done[d] !== 1'b1 && n < 40) begin
            chk("busy_during_spawn", 32'(busy[d]), 1);
            req[d] = (intrude >= 0 && n == 2);
            if (intrude >= 0) idx[d] = 3'(intrude);
            clr[d] = clr_commit && (n == lat - 1);
            tick();
            n++;
        end
        req[d] = 1'b0; clr[d] = 1'b0;
        chk("spawn_latency", n, lat);
        chk("spawn_done",    32'(done[d]), 1);
        chk("busy_after",    32'(busy[d]), 0);
        if (clr_commit) mmask[d] = 1 << slot;
        else            mmask[d] |= 1 << slot;
        mx[d][slot] = ex;
        my[d][slot] = ey;
        chk("valid_mask", 32'(mask[d]), 32'(mmask[d]));
        check_slot(d, slot);
    endtask

    int sx [4];
    int sy [4];

    initial begin
        do_reset();

        // Full window: best-case latency, single-cycle done pulse
        spawn(0, 2, 1'b0, -1);
        chk("full_mask_0100", 32'(mask[0]), 32'h4);
        chk("done_one_cycle", 32'(done[0]), 0);

        // Request to slot 1 during GEN phase is dropped
        spawn(0, 0, 1'b0, 1);
        repeat (6) begin
            tick();
            chk("no_second_done", 32'(done[0]), 0);
            chk("no_second_busy", 32'(busy[0]), 0);
        end
        chk("mask_after_intrude", 32'(mask[0]), 32'h5);

        // Out-of-range slot index is ignored
        req[0] = 1'b1; idx[0] = 3'd5;
        tick();
        req[0] = 1'b0;
        repeat (4) begin
            tick();
            chk("badidx_busy", 32'(busy[0]), 0);
            chk("badidx_done", 32'(done[0]), 0);
        end
        chk("badidx_mask", 32'(mask[0]), 32'h5);
        check_slot(0, 6);

        // Fill all slots, then clear coincident with COMMIT of slot 1
        spawn(0, 1, 1'b0, -1);
        spawn(0, 3, 1'b0, -1);
        chk("mask_full", 32'(mask[0]), 32'hF);
        spawn(0, 1, 1'b1, -1);
        chk("clear_commit_mask", 32'(mask[0]), 32'h2);
        check_slot(0, 0);
        check_slot(0, 2);

        // Single-point window: draws clamp or land on the window point
        spawn(1, 0, 1'b0, -1);
        chk("narrow_x", 32'(rdx[1]), 100);
        chk("narrow_y", 32'(rdy[1]), 200);
        spawn(1, 3, 1'b0, -1);

        // Random spawns, clears and reads on the default window
        for (int it = 0; it < 24; it++) begin
            int slot, gap;
            slot = int'($urandom_range(0, 3));
            gap  = int'($urandom_range(0, 3));
            repeat (gap) tick();
            if ($urandom_range(0, 4) == 0) begin
                clr[2] = 1'b1;
                tick();
                clr[2] = 1'b0;
                mmask[2] = 0;
                chk("rand_clear_mask", 32'(mask[2]), 0);
            end
            spawn(2, slot, ($urandom_range(0, 5) == 0), -1);
            check_slot(2, int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a spawn abandons it
        rdi[2] = 3'd0;
        req[2] = 1'b1; idx[2] = 3'd3;
        tick();
        req[2] = 1'b0;
        tick();
        tick();
        do_reset();
        repeat (6) begin
            tick();
            chk("abandon_done", 32'(done[2]), 0);
            chk("abandon_busy", 32'(busy[2]), 0);
            chk("abandon_mask", 32'(mask[2]), 0);
        end

        // Same sequence after reset yields identical coordinates
        do_reset();
        for (int s = 0; s < 4; s++) begin
            spawn(2, s, 1'b0, -1);
            sx[s] = mx[2][s];
            sy[s] = my[2][s];
        end
        do_reset();
        for (int s = 0; s < 4; s++) begin
            spawn(2, s, 1'b0, -1);
            chk("determinism_x", 32'(rdx[2]), 32'(sx[s]));
            chk("determinism_y", 32'(rdy[2]), 32'(sy[s]));
        end
        chk("determinism_mask", 32'(mask[2]), 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
